// File: rtl/result_packetizer.sv
// result_packetizer
//   Captures one ALU result (opcode, result word, byte count) and sends it to
//   the UART TX stage as a byte stream over ready/valid:
//     byte 0     opcode
//     byte 1     RESERVED_BYTE_P
//     bytes 2-3  total packet length (4 + n), LSB first
//     payload    n result bytes, LSB first
//
// Ports
//   clk             system clock
//   rst             asynchronous active-low reset
//   opcode_i        opcode echoed in header byte 0
//   result_i        result word, byte k = result_i[8k+7:8k]
//   nbytes_i        payload byte count (clamped to MAX_BYTES_P)
//   result_valid_i  result/opcode/nbytes valid
//   result_ready_o  block can accept a result (IDLE only)
//   data_o          TX byte
//   valid_o         data_o valid
//   ready_i         TX stage accepts byte
//   busy_o          packet in progress
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for a result, result_ready_o=1
// OP    | sending captured opcode
// RSV   | sending reserved byte
// LEN_L | sending packet length, low byte
// LEN_H | sending packet length, high byte
// DATA  | sending payload byte idx, LSB first

module result_packetizer #(
  parameter int          MAX_BYTES_P     = 8,
  parameter logic [7:0]  RESERVED_BYTE_P = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               opcode_i,
  input  logic [8*MAX_BYTES_P-1:0] result_i,
  input  logic [3:0]               nbytes_i,
  input  logic                     result_valid_i,
  output logic                     result_ready_o,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o
);

  localparam int IDX_W = (MAX_BYTES_P > 1) ? $clog2(MAX_BYTES_P) : 1;

  typedef enum logic [2:0] {IDLE, OP, RSV, LEN_L, LEN_H, DATA} state_t;

  state_t                   state;
  logic [7:0]               opcode_q;
  logic [8*MAX_BYTES_P-1:0] result_q;
  logic [3:0]               n_q;
  logic [IDX_W-1:0]         idx;

  logic [3:0]       n_clamp;
  logic [15:0]      len_w;
  logic [IDX_W-1:0] idx_nxt;
  logic             last_byte;

  assign n_clamp   = (nbytes_i > 4'(MAX_BYTES_P)) ? 4'(MAX_BYTES_P) : nbytes_i;
  assign len_w     = 16'd4 + 16'(n_q);
  assign idx_nxt   = idx + IDX_W'(1);
  assign last_byte = (4'(idx) == (n_q - 4'd1));

  function automatic logic [7:0] result_byte(input logic [IDX_W-1:0] k);
    return result_q[8*k +: 8];
  endfunction

  // Outputs are registered alongside the state: each branch loads the byte
  // belonging to the state being entered, so data_o only changes on a
  // transfer and is held while the TX stage stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      opcode_q       <= '0;
      result_q       <= '0;
      n_q            <= '0;
      idx            <= '0;
      data_o         <= '0;
      valid_o        <= 1'b0;
      busy_o         <= 1'b0;
      result_ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (result_valid_i && result_ready_o) begin
            opcode_q       <= opcode_i;
            result_q       <= result_i;
            n_q            <= n_clamp;
            idx            <= '0;
            state          <= OP;
            data_o         <= opcode_i;
            valid_o        <= 1'b1;
            busy_o         <= 1'b1;
            result_ready_o <= 1'b0;
          end else begin
            result_ready_o <= 1'b1;
          end
        end
        OP: begin
          if (ready_i) begin
            state  <= RSV;
            data_o <= RESERVED_BYTE_P;
          end
        end
        RSV: begin
          if (ready_i) begin
            state  <= LEN_L;
            data_o <= len_w[7:0];
          end
        end
        LEN_L: begin
          if (ready_i) begin
            state  <= LEN_H;
            data_o <= len_w[15:8];
          end
        end
        LEN_H: begin
          if (ready_i) begin
            if (n_q != 4'd0) begin
              state  <= DATA;
              idx    <= '0;
              data_o <= result_byte('0);
            end else begin
              state          <= IDLE;
              data_o         <= '0;
              valid_o        <= 1'b0;
              busy_o         <= 1'b0;
              result_ready_o <= 1'b1;
            end
          end
        end
        DATA: begin
          if (ready_i) begin
            if (last_byte) begin
              state          <= IDLE;
              data_o         <= '0;
              valid_o        <= 1'b0;
              busy_o         <= 1'b0;
              result_ready_o <= 1'b1;
            end else begin
              idx    <= idx_nxt;
              data_o <= result_byte(idx_nxt);
            end
          end
        end
        default: begin
          state          <= IDLE;
          valid_o        <= 1'b0;
          busy_o         <= 1'b0;
          result_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_packetizer.sv
module tb_result_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  opcode_i = '0;
  logic [63:0] result_i = '0;
  logic [3:0]  nbytes_i = '0;
  logic        result_valid_i = 1'b0;
  logic        result_ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  result_packetizer #(.MAX_BYTES_P(8), .RESERVED_BYTE_P(8'h00)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .result_i(result_i),
    .nbytes_i(nbytes_i), .result_valid_i(result_valid_i),
    .result_ready_o(result_ready_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [63:0] res;
    logic [3:0]  nb;
    bit          stall;
    logic [7:0]  exp_len;  // hand-derived length byte
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_expected(input logic [7:0] op, input logic [63:0] res,
                               input logic [3:0] nb, input logic [7:0] len);
    logic [63:0] r;
    int n;
    r = res;
    n = (nb > 8) ? 8 : int'(nb);
    exp_q.push_back(op);
    exp_q.push_back(8'h00);
    exp_q.push_back(len);
    exp_q.push_back(8'h00);
    for (int k = 0; k < n; k++) exp_q.push_back(r[8*k +: 8]);
  endtask

  task automatic accept(input logic [7:0] op, input logic [63:0] res, input logic [3:0] nb);
    @(negedge clk);
    check("ready_before_accept", result_ready_o, 1'b1);
    opcode_i = op; result_i = res; nbytes_i = nb; result_valid_i = 1'b1;
    @(posedge clk);
    #1 result_valid_i = 1'b0;
  endtask

  // Transfers cnt bytes, comparing each against the scoreboard.
  task automatic drain(input bit stall, input int cnt, input int exp_cycles, input bit idle_check);
    int popped = 0;
    int cyc = 0;
    bit stalled_prev = 0;
    logic [7:0] prev_data = '0;
    logic [7:0] want;
    while (popped < cnt && cyc < 500) begin
      @(negedge clk);
      ready_i = stall ? (cyc % 3 == 0) : 1'b1;
      #1;
      check("valid_mid_packet", valid_o, 1'b1);
      if (stalled_prev) check("stall_hold", data_o, prev_data);
      if (ready_i) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1'b1, 1'b0);
        end else begin
          want = exp_q.pop_front();
          check("byte", data_o, want);
        end
        popped++;
      end
      stalled_prev = !ready_i;
      prev_data    = data_o;
      cyc++;
    end
    if (popped < cnt) check("drain_timeout", popped, cnt);
    if (exp_cycles > 0) check("packet_cycles", cyc, exp_cycles);
    if (idle_check) begin
      @(negedge clk);
      #1;
      check("idle_ready", result_ready_o, 1'b1);
      check("idle_valid", valid_o, 1'b0);
      check("idle_busy", busy_o, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{8'h01, 64'h12345678,         4'd4,  1'b0, 8'h08};
    vecs[1] = '{8'h01, 64'h12345678,         4'd4,  1'b1, 8'h08};
    vecs[2] = '{8'hEC, 64'h0,                4'd0,  1'b0, 8'h04};
    vecs[3] = '{8'h55, 64'h8877665544332211, 4'd9,  1'b0, 8'h0C};
    vecs[4] = '{8'hA5, 64'hDEADBEEFCAFEF00D, 4'd8,  1'b1, 8'h0C};
    vecs[5] = '{8'h3C, 64'h0123456789ABCDEF, 4'd15, 1'b0, 8'h0C};
    vecs[6] = '{8'h77, 64'hFFFFFFFFFFFFFF5A, 4'd1,  1'b1, 8'h05};

    // Reset state
    #12;
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ready", result_ready_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", result_ready_o, 1'b1);

    // Table-driven packets
    for (int i = 0; i < 7; i++) begin
      int n;
      n = (vecs[i].nb > 8) ? 8 : int'(vecs[i].nb);
      push_expected(vecs[i].op, vecs[i].res, vecs[i].nb, vecs[i].exp_len);
      accept(vecs[i].op, vecs[i].res, vecs[i].nb);
      drain(vecs[i].stall, 4 + n, vecs[i].stall ? 0 : 4 + n, 1'b1);
    end

    // Reset mid-packet, after the LEN_L transfer
    push_expected(8'h01, 64'h9999, 4'd2, 8'h06);
    accept(8'h01, 64'h9999, 4'd2);
    drain(1'b0, 3, 0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_ready", result_ready_o, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    push_expected(8'h01, 64'hAB, 4'd1, 8'h05);
    accept(8'h01, 64'hAB, 4'd1);
    drain(1'b0, 5, 5, 1'b1);

    // Back-to-back with result_valid_i held high; inputs change while busy
    push_expected(8'h21, 64'hBEEF, 4'd2, 8'h06);
    push_expected(8'h42, 64'h030201, 4'd3, 8'h07);
    @(negedge clk);
    opcode_i = 8'h21; result_i = 64'hBEEF; nbytes_i = 4'd2; result_valid_i = 1'b1;
    @(posedge clk);
    #1;
    opcode_i = 8'hFF; result_i = '1; nbytes_i = 4'd8;
    drain(1'b0, 3, 0, 1'b0);
    opcode_i = 8'h42; result_i = 64'h030201; nbytes_i = 4'd3;
    drain(1'b0, 3, 0, 1'b0);
    @(negedge clk);
    #1;
    check("b2b_bubble_valid", valid_o, 1'b0);
    check("b2b_bubble_ready", result_ready_o, 1'b1);
    @(posedge clk);
    #1 result_valid_i = 1'b0;
    drain(1'b0, 7, 7, 1'b1);
    check("scoreboard_empty", exp_q.size(), 0);

    // ready_i while idle has no effect
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_noeffect", valid_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
